serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 109 ++++++++++
 tb/tb_serial_adder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands one bit per clock, LSB first.
// Optional carry-in port is enabled by defining SERIAL_ADDER_CIN_EN.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_CIN_EN
   input  logic             cin,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c
);

   // Sized to hold WIDTH itself, so the count never wraps during RUN.
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] acc;
   logic             carry_q;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             last_bit;
   logic             carry_init;
   logic             h1_s;
   logic             h1_c;
   logic             h2_c;
   logic             fa_s;
   logic             fa_c;

   // Full adder built from two half-adder stages and an OR.
   assign h1_s = op_a[0] ^ op_b[0];
   assign h1_c = op_a[0] & op_b[0];
   assign fa_s = h1_s ^ carry_q;
   assign h2_c = h1_s & carry_q;
   assign fa_c = h1_c | h2_c;

   assign accept   = (state == IDLE) && start;
   assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));
   assign busy     = (state == RUN);

`ifdef SERIAL_ADDER_CIN_EN
   assign carry_init = cin;
`else
   assign carry_init = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start)    state_next = RUN;
         RUN:     if (last_bit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath; done defaults low so it can only ever be a one-cycle pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a    <= '0;
         op_b    <= '0;
         acc     <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
         s       <= '0;
         c       <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            op_a    <= a;
            op_b    <= b;
            acc     <= '0;
            carry_q <= carry_init;
            cnt     <= '0;
         end else if (state == RUN) begin
            op_a    <= op_a >> 1;
            op_b    <= op_b >> 1;
            acc     <= {fa_s, acc[WIDTH-1:1]};
            carry_q <= fa_c;
            cnt     <= cnt + 1'b1;
            if (last_bit) begin
               s    <= {fa_s, acc[WIDTH-1:1]};
               c    <= fa_c;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8); carry-in cases run only when
// SERIAL_ADDER_CIN_EN is defined.
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic             clk   = 1'b0;
   logic             rst   = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a     = '0;
   logic [WIDTH-1:0] b     = '0;
`ifdef SERIAL_ADDER_CIN_EN
   logic             cin   = 1'b0;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             c;

   int          n_compared    = 0;
   int          n_mismatched  = 0;
   int          done_count    = 0;
   int          done_expected = 0;
   int          cyc;
   int          cyc2;
   logic [8:0]  exp_q[$];
   logic [8:0]  mon_exp;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SERIAL_ADDER_CIN_EN
      .cin   (cin),
`endif
      .busy  (busy),
      .done  (done),
      .s     (s),
      .c     (c)
   );

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                                 input logic [WIDTH-1:0] s_exp, input logic c_exp);
      a     = op_a;
      b     = op_b;
      start = 1'b1;
      exp_q.push_back({s_exp, c_exp});
      done_expected++;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cycles);
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
      end while (!done && cycles < limit);
      if (!done) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL done_timeout: got no done after %0d cycles, want done", cycles);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (done) begin
         done_count++;
         check_output("busy_with_done", busy, 0);
         if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected_done: got s=0x%0h c=%0b, want no done", s, c);
         end else begin
            mon_exp = exp_q.pop_front();
            check_output("sum", s, mon_exp[8:1]);
            check_output("carry", c, mon_exp[0]);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running, want finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state, with start held high to show it is ignored under reset.
      start = 1'b1;
      a     = 8'h55;
      b     = 8'h55;
      #2;
      check_output("reset_busy", busy, 0);
      check_output("reset_done", done, 0);
      check_output("reset_s", s, 0);
      check_output("reset_c", c, 0);
      @(posedge clk);
      #1;
      check_output("busy_in_reset", busy, 0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      apply_stimulus(8'h00, 8'h01, 8'h01, 1'b0);
      check_output("busy_after_accept", busy, 1);
      wait_done(20, cyc);
      check_output("latency_00_01", cyc, 8);
      @(posedge clk);
      #1;
      check_output("done_one_cycle", done, 0);

      apply_stimulus(8'hFF, 8'h01, 8'h00, 1'b1);
      wait_done(20, cyc);
      apply_stimulus(8'hA5, 8'h5A, 8'hFF, 1'b0);
      wait_done(20, cyc);

      // Start pulsed during RUN cycle 3 must be ignored.
      apply_stimulus(8'h10, 8'h20, 8'h30, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      a     = 8'h11;
      b     = 8'h22;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(20, cyc);
      check_output("latency_ignored_start", cyc, 5);
      repeat (12) begin
         @(posedge clk);
         #1;
      end
      check_output("no_extra_done", done_count, done_expected);
      check_output("s_held", s, 8'h30);
      check_output("busy_idle", busy, 0);

      // Back-to-back: start held through the done cycle.
      apply_stimulus(8'h03, 8'h04, 8'h07, 1'b0);
      a     = 8'h01;
      b     = 8'h01;
      start = 1'b1;
      exp_q.push_back({8'h02, 1'b0});
      done_expected++;
      wait_done(20, cyc);
      check_output("latency_first_b2b", cyc, 8);
      @(posedge clk);
      #1;
      start = 1'b0;
      check_output("busy_after_b2b_accept", busy, 1);
      wait_done(20, cyc2);
      check_output("b2b_spacing", cyc2 + 1, 9);

      // Reset asserted in RUN cycle 4 aborts the operation.
      a     = 8'h12;
      b     = 8'h34;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("abort_busy", busy, 0);
      check_output("abort_done", done, 0);
      check_output("abort_s", s, 0);
      check_output("abort_c", c, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      apply_stimulus(8'h12, 8'h34, 8'h46, 1'b0);
      wait_done(20, cyc);
      check_output("latency_after_abort", cyc, 8);

      apply_stimulus(8'h7F, 8'h81, 8'h00, 1'b1);
      wait_done(20, cyc);

`ifdef SERIAL_ADDER_CIN_EN
      cin = 1'b1;
      apply_stimulus(8'hFF, 8'h00, 8'h00, 1'b1);
      wait_done(20, cyc);
      cin = 1'b0;
      apply_stimulus(8'hFF, 8'h00, 8'hFF, 1'b0);
      wait_done(20, cyc);
`endif

      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check_output("pending_results", exp_q.size(), 0);
      check_output("done_count", done_count, done_expected);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
